// File: rtl/rsa_host_sequencer.sv
// Host-side job sequencer for the RSA accelerator: programs key and start over AXI4-Lite,
// polls for completion, reads the result and streams the trace buffer out.
module rsa_host_sequencer #(
    parameter int C_M_AXI_ADDR_WIDTH = 16,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int POLL_MAX           = 10000
) (
    input  logic                            CLOCK,
    input  logic                            RESET,
    input  logic                            CMD_START,
    input  logic [31:0]                     CMD_KEY,
    input  logic [14:0]                     CMD_LEN,
    output logic                            BUSY,
    output logic                            DONE,
    output logic [1:0]                      ERR,
    output logic [31:0]                     RESULT,
    output logic [31:0]                     TRACE_DATA,
    output logic                            TRACE_VALID,
    input  logic                            TRACE_READY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WR_KEY    = 3'd1;
    localparam logic [2:0] S_WR_START  = 3'd2;
    localparam logic [2:0] S_POLL      = 3'd3;
    localparam logic [2:0] S_RD_RESULT = 3'd4;
    localparam logic [2:0] S_RD_TRACE  = 3'd5;
    localparam logic [2:0] S_OUT_TRACE = 3'd6;
    localparam logic [2:0] S_FINISH    = 3'd7;

    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_RESULT = C_M_AXI_ADDR_WIDTH'(16'hFFF0);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_STATUS = C_M_AXI_ADDR_WIDTH'(16'hFFF4);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_KEY    = C_M_AXI_ADDR_WIDTH'(16'hFFF8);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_START  = C_M_AXI_ADDR_WIDTH'(16'hFFFC);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_BUS     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    logic [2:0]  state;
    logic [14:0] len_q;
    logic [14:0] idx;
    logic [31:0] poll_cnt;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] trace_addr(input logic [14:0] i);
        return C_M_AXI_ADDR_WIDTH'({2'b00, i[13:0]});
    endfunction

    assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID  & M_AXI_WREADY;
    assign b_hs  = M_AXI_BREADY  & M_AXI_BVALID;
    assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_hs  = M_AXI_RREADY  & M_AXI_RVALID;

    assign DONE        = (state == S_FINISH);
    assign M_AXI_WSTRB = '1;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state         <= S_IDLE;
            BUSY          <= 1'b0;
            ERR           <= ERR_OK;
            RESULT        <= '0;
            TRACE_DATA    <= '0;
            TRACE_VALID   <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            len_q         <= '0;
            idx           <= '0;
            poll_cnt      <= '0;
        end else begin
            // Address/data valids retire on their own handshakes; R is only accepted after AR.
            if (aw_hs) M_AXI_AWVALID <= 1'b0;
            if (w_hs)  M_AXI_WVALID  <= 1'b0;
            if (ar_hs) begin
                M_AXI_ARVALID <= 1'b0;
                M_AXI_RREADY  <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (CMD_START) begin
                        state         <= S_WR_KEY;
                        BUSY          <= 1'b1;
                        ERR           <= ERR_OK;
                        len_q         <= CMD_LEN;
                        M_AXI_AWADDR  <= ADDR_KEY;
                        M_AXI_WDATA   <= C_M_AXI_DATA_WIDTH'(CMD_KEY);
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        M_AXI_BREADY  <= 1'b1;
                    end
                end
                S_WR_KEY, S_WR_START: begin
                    if (b_hs) begin
                        M_AXI_BREADY <= 1'b0;
                        if (M_AXI_BRESP != 2'b00) begin
                            ERR   <= ERR_BUS;
                            state <= S_FINISH;
                        end else if (state == S_WR_KEY) begin
                            state         <= S_WR_START;
                            M_AXI_AWADDR  <= ADDR_START;
                            M_AXI_WDATA   <= C_M_AXI_DATA_WIDTH'(1);
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            M_AXI_BREADY  <= 1'b1;
                        end else begin
                            state         <= S_POLL;
                            poll_cnt      <= '0;
                            M_AXI_ARADDR  <= ADDR_STATUS;
                            M_AXI_ARVALID <= 1'b1;
                        end
                    end
                end
                S_POLL: begin
                    if (r_hs) begin
                        M_AXI_RREADY <= 1'b0;
                        if (M_AXI_RRESP != 2'b00) begin
                            ERR   <= ERR_BUS;
                            state <= S_FINISH;
                        end else if (M_AXI_RDATA[0]) begin
                            state         <= S_RD_RESULT;
                            M_AXI_ARADDR  <= ADDR_RESULT;
                            M_AXI_ARVALID <= 1'b1;
                        end else if (poll_cnt == 32'(POLL_MAX - 1)) begin
                            ERR   <= ERR_TIMEOUT;
                            state <= S_FINISH;
                        end else begin
                            poll_cnt      <= poll_cnt + 32'd1;
                            M_AXI_ARADDR  <= ADDR_STATUS;
                            M_AXI_ARVALID <= 1'b1;
                        end
                    end
                end
                S_RD_RESULT: begin
                    if (r_hs) begin
                        M_AXI_RREADY <= 1'b0;
                        RESULT       <= 32'(M_AXI_RDATA);
                        if (M_AXI_RRESP != 2'b00) begin
                            ERR   <= ERR_BUS;
                            state <= S_FINISH;
                        end else if (len_q == 15'd0) begin
                            state <= S_FINISH;
                        end else begin
                            state         <= S_RD_TRACE;
                            idx           <= '0;
                            M_AXI_ARADDR  <= trace_addr(15'd0);
                            M_AXI_ARVALID <= 1'b1;
                        end
                    end
                end
                S_RD_TRACE: begin
                    if (r_hs) begin
                        M_AXI_RREADY <= 1'b0;
                        if (M_AXI_RRESP != 2'b00) begin
                            ERR   <= ERR_BUS;
                            state <= S_FINISH;
                        end else begin
                            TRACE_DATA  <= 32'(M_AXI_RDATA);
                            TRACE_VALID <= 1'b1;
                            state       <= S_OUT_TRACE;
                        end
                    end
                end
                S_OUT_TRACE: begin
                    // Next trace read is held back until the current word leaves.
                    if (TRACE_READY) begin
                        TRACE_VALID <= 1'b0;
                        if (idx == len_q - 15'd1) begin
                            state <= S_FINISH;
                        end else begin
                            idx           <= idx + 15'd1;
                            M_AXI_ARADDR  <= trace_addr(idx + 15'd1);
                            M_AXI_ARVALID <= 1'b1;
                            state         <= S_RD_TRACE;
                        end
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_host_sequencer.sv
// Directed bench for rsa_host_sequencer: behavioural AXI4-Lite slave and trace sink
// on the falling edge, directed job sequence with immediate assertions.
module tb_rsa_host_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        RESET, CMD_START;
    logic [31:0] CMD_KEY;
    logic [14:0] CMD_LEN;
    logic        BUSY, DONE, TRACE_VALID;
    logic [1:0]  ERR;
    logic [31:0] RESULT, TRACE_DATA;
    logic        TRACE_READY = 1'b0;
    logic [15:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
    logic        M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
    logic [1:0]  M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
    logic [31:0] M_AXI_RDATA = 32'd0;

    rsa_host_sequencer #(.POLL_MAX(8)) dut (
        .CLOCK(clk), .RESET(RESET), .CMD_START(CMD_START), .CMD_KEY(CMD_KEY), .CMD_LEN(CMD_LEN),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RESULT(RESULT), .TRACE_DATA(TRACE_DATA),
        .TRACE_VALID(TRACE_VALID), .TRACE_READY(TRACE_READY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    // Slave configuration, written by the directed sequence.
    bit          sl_reset = 1'b1;
    int          aw_delay = 0, w_delay = 0, trace_hold = 0;
    int          poll_ready_at = 1, err_trace_idx = -1;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [31:0] result_val = 32'd0;

    // Slave observations.
    int          naw, nb, nrd, poll_n, res_reads, ntr, viol, done_cnt;
    logic [15:0] wr_addr [16];
    logic [31:0] wr_data [16];
    logic [15:0] ar_log [32];
    logic [31:0] trace_log [16];

    bit          aw_got, w_got, r_pend, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    int          aw_wait, w_wait, hold_cnt;
    logic [15:0] wa_q, ra_q, awa_prev, ara_prev;
    logic [31:0] wd_q, wd_prev, td_prev;
    bit          awv_prev, awr_prev, wv_prev, wr_prev, arv_prev, arr_prev, tv_prev, tr_prev;

    always @(negedge clk) begin
        if (sl_reset) begin
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
            M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0; TRACE_READY = 0;
            aw_got = 0; w_got = 0; r_pend = 0; aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
            aw_wait = 0; w_wait = 0; hold_cnt = 0;
            naw = 0; nb = 0; nrd = 0; poll_n = 0; res_reads = 0; ntr = 0; viol = 0; done_cnt = 0;
            awv_prev = 0; awr_prev = 0; wv_prev = 0; wr_prev = 0; arv_prev = 0; arr_prev = 0;
            tv_prev = 0; tr_prev = 0;
        end else begin
            if (aw_hs) aw_got = 1;
            if (w_hs)  w_got = 1;
            if (b_hs) begin aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; end
            if (r_hs)  r_pend = 0;
            if (ar_hs) r_pend = 1;

            // Protocol rules: valids held with stable payload until accepted, one read outstanding.
            if (awv_prev && !awr_prev && (!M_AXI_AWVALID || M_AXI_AWADDR !== awa_prev)) viol++;
            if (wv_prev && !wr_prev && (!M_AXI_WVALID || M_AXI_WDATA !== wd_prev)) viol++;
            if (arv_prev && !arr_prev && (!M_AXI_ARVALID || M_AXI_ARADDR !== ara_prev)) viol++;
            if (M_AXI_ARVALID && (r_pend || TRACE_VALID)) viol++;

            if (M_AXI_AWVALID && !aw_got) begin
                M_AXI_AWREADY = (aw_wait >= aw_delay);
                if (!M_AXI_AWREADY) aw_wait++;
            end else M_AXI_AWREADY = 0;
            aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
            if (aw_hs) begin wa_q = M_AXI_AWADDR; naw++; end

            if (M_AXI_WVALID && !w_got) begin
                M_AXI_WREADY = (w_wait >= w_delay);
                if (!M_AXI_WREADY) w_wait++;
            end else M_AXI_WREADY = 0;
            w_hs = M_AXI_WVALID && M_AXI_WREADY;
            if (w_hs) wd_q = M_AXI_WDATA;

            M_AXI_BVALID = aw_got && w_got;
            M_AXI_BRESP  = M_AXI_BVALID ? bresp_cfg : 2'b00;
            b_hs = M_AXI_BVALID && M_AXI_BREADY;
            if (b_hs) begin
                if (nb < 16) begin wr_addr[nb] = wa_q; wr_data[nb] = wd_q; end
                nb++;
            end

            M_AXI_ARREADY = M_AXI_ARVALID && !r_pend;
            ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
            if (ar_hs) begin
                ra_q = M_AXI_ARADDR;
                if (nrd < 32) ar_log[nrd] = M_AXI_ARADDR;
                nrd++;
                if (M_AXI_ARADDR == 16'hFFF4) poll_n++;
                if (M_AXI_ARADDR == 16'hFFF0) res_reads++;
            end

            M_AXI_RVALID = r_pend;
            if (r_pend) begin
                if (ra_q == 16'hFFF4) begin
                    M_AXI_RDATA = (poll_ready_at != 0 && poll_n >= poll_ready_at) ? 32'd1 : 32'd0;
                    M_AXI_RRESP = 2'b00;
                end else if (ra_q == 16'hFFF0) begin
                    M_AXI_RDATA = result_val;
                    M_AXI_RRESP = 2'b00;
                end else begin
                    M_AXI_RDATA = 32'd10 + 32'(ra_q);
                    M_AXI_RRESP = (int'(ra_q) == err_trace_idx) ? 2'b10 : 2'b00;
                end
            end else begin
                M_AXI_RDATA = 0;
                M_AXI_RRESP = 0;
            end
            r_hs = M_AXI_RVALID && M_AXI_RREADY;

            // Trace sink: hold off trace_hold cycles per word, word must stay stable meanwhile.
            if (TRACE_VALID) begin
                if (tv_prev && !tr_prev && TRACE_DATA !== td_prev) viol++;
                TRACE_READY = (hold_cnt >= trace_hold);
                if (TRACE_READY) begin
                    if (ntr < 16) trace_log[ntr] = TRACE_DATA;
                    ntr++;
                    hold_cnt = 0;
                end else hold_cnt++;
            end else begin
                TRACE_READY = 0;
                hold_cnt = 0;
            end

            if (DONE) done_cnt++;

            awv_prev = M_AXI_AWVALID; awr_prev = M_AXI_AWREADY; awa_prev = M_AXI_AWADDR;
            wv_prev = M_AXI_WVALID; wr_prev = M_AXI_WREADY; wd_prev = M_AXI_WDATA;
            arv_prev = M_AXI_ARVALID; arr_prev = M_AXI_ARREADY; ara_prev = M_AXI_ARADDR;
            tv_prev = TRACE_VALID; tr_prev = TRACE_READY; td_prev = TRACE_DATA;
        end
    end

    int nvec = 0, nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_slave();
        sl_reset = 1'b1;
        tick();
        sl_reset = 1'b0;
    endtask

    task automatic start_job(input logic [31:0] key, input logic [14:0] len);
        CMD_KEY   = key;
        CMD_LEN   = len;
        CMD_START = 1'b1;
        tick();
        CMD_START = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int  n;
        bit  got;
        n = 0;
        got = 0;
        while (!got && n < 3000) begin
            tick();
            n++;
            if (DONE === 1'b1) got = 1;
        end
        chk({tag, "_done"}, 32'(got), 1);
        chk({tag, "_valids_in_finish"}, 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}), 0);
    endtask

    initial begin
        RESET = 1'b1; CMD_START = 1'b0; CMD_KEY = '0; CMD_LEN = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_done", 32'(DONE), 0);
        chk("rst_err", 32'(ERR), 0);
        chk("rst_result", RESULT, 0);
        chk("rst_trace_data", TRACE_DATA, 0);
        chk("rst_trace_valid", 32'(TRACE_VALID), 0);
        chk("rst_axi_ctl", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 0);
        chk("wstrb", 32'(M_AXI_WSTRB), 32'hF);
        RESET = 1'b0;
        sl_reset = 1'b0;
        tick();

        // Key 3, no trace, ready on third poll; a stray start mid-job must be ignored.
        poll_ready_at = 3;
        result_val = 32'hDEADBEEF;
        start_job(32'd3, 15'd0);
        chk("a_busy_rise", 32'(BUSY), 1);
        chk("a_awaddr", 32'(M_AXI_AWADDR), 32'hFFF8);
        chk("a_awvalid_wvalid", 32'({M_AXI_AWVALID, M_AXI_WVALID}), 32'h3);
        tick();
        CMD_KEY = 32'd7; CMD_START = 1'b1;
        tick();
        CMD_START = 1'b0;
        wait_done("a");
        chk("a_err", 32'(ERR), 0);
        chk("a_result", RESULT, 32'hDEADBEEF);
        chk("a_busy_in_finish", 32'(BUSY), 1);
        tick();
        chk("a_busy_fall", 32'(BUSY), 0);
        chk("a_writes", 32'(nb), 2);
        chk("a_wr0_addr", 32'(wr_addr[0]), 32'hFFF8);
        chk("a_wr0_data", wr_data[0], 32'd3);
        chk("a_wr1_addr", 32'(wr_addr[1]), 32'hFFFC);
        chk("a_wr1_data", wr_data[1], 32'd1);
        chk("a_polls", 32'(poll_n), 3);
        chk("a_reads", 32'(nrd), 4);
        chk("a_result_reads", 32'(res_reads), 1);
        chk("a_done_pulses", 32'(done_cnt), 1);
        repeat (3) tick();
        chk("a_stray_start_ignored", 32'({BUSY, 1'b0}) | 32'(nb), 2);
        chk("a_viol", 32'(viol), 0);

        // Four trace words with a slow sink.
        clr_slave();
        poll_ready_at = 1;
        trace_hold = 5;
        start_job(32'h55, 15'd4);
        wait_done("b");
        chk("b_err", 32'(ERR), 0);
        tick();
        chk("b_words", 32'(ntr), 4);
        for (int i = 0; i < 4; i++) begin
            chk("b_trace_word", trace_log[i], 32'(10 + i));
            chk("b_trace_araddr", 32'(ar_log[2 + i]), 32'(i));
        end
        chk("b_reads", 32'(nrd), 6);
        chk("b_viol", 32'(viol), 0);
        chk("b_done_pulses", 32'(done_cnt), 1);
        trace_hold = 0;

        // Skewed address/data acceptance, both orders.
        clr_slave();
        aw_delay = 3; w_delay = 0;
        start_job(32'hA5, 15'd0);
        wait_done("c1");
        tick();
        chk("c1_aw", 32'(naw), 2);
        chk("c1_b", 32'(nb), 2);
        chk("c1_wdata", wr_data[0], 32'hA5);
        chk("c1_viol", 32'(viol), 0);
        clr_slave();
        aw_delay = 0; w_delay = 3;
        start_job(32'h5A, 15'd0);
        wait_done("c2");
        tick();
        chk("c2_aw", 32'(naw), 2);
        chk("c2_b", 32'(nb), 2);
        chk("c2_wdata", wr_data[0], 32'h5A);
        chk("c2_err", 32'(ERR), 0);
        chk("c2_viol", 32'(viol), 0);
        w_delay = 0;

        // Status never ready: timeout after exactly POLL_MAX polls, RESULT untouched.
        clr_slave();
        poll_ready_at = 0;
        result_val = 32'h12345678;
        start_job(32'd1, 15'd0);
        wait_done("d");
        chk("d_err", 32'(ERR), 2);
        chk("d_result_held", RESULT, 32'hDEADBEEF);
        tick();
        chk("d_polls", 32'(poll_n), 8);
        chk("d_result_reads", 32'(res_reads), 0);
        chk("d_done_pulses", 32'(done_cnt), 1);
        repeat (3) tick();
        chk("d_err_held", 32'(ERR), 2);

        // Ready on the last allowed poll still succeeds; ERR cleared on acceptance.
        clr_slave();
        poll_ready_at = 8;
        start_job(32'd1, 15'd0);
        chk("e_err_cleared", 32'(ERR), 0);
        wait_done("e");
        chk("e_err", 32'(ERR), 0);
        chk("e_result", RESULT, 32'h12345678);
        tick();
        chk("e_polls", 32'(poll_n), 8);
        chk("e_result_reads", 32'(res_reads), 1);

        // Error read response on trace word 2 of 4.
        clr_slave();
        poll_ready_at = 1;
        err_trace_idx = 2;
        start_job(32'd2, 15'd4);
        wait_done("f");
        chk("f_err", 32'(ERR), 1);
        tick();
        chk("f_words", 32'(ntr), 2);
        chk("f_reads", 32'(nrd), 5);
        chk("f_last_araddr", 32'(ar_log[4]), 32'd2);
        chk("f_done_pulses", 32'(done_cnt), 1);
        err_trace_idx = -1;

        // Error write response on the key write skips everything else.
        clr_slave();
        bresp_cfg = 2'b10;
        start_job(32'd6, 15'd2);
        wait_done("g");
        chk("g_err", 32'(ERR), 1);
        tick();
        chk("g_b", 32'(nb), 1);
        chk("g_reads", 32'(nrd), 0);
        bresp_cfg = 2'b00;

        // Reset while a write is stalled, then a normal job.
        clr_slave();
        aw_delay = 20;
        start_job(32'd9, 15'd1);
        repeat (3) tick();
        chk("h_stalled_awvalid", 32'(M_AXI_AWVALID), 1);
        RESET = 1'b1;
        sl_reset = 1'b1;
        tick();
        chk("h_rst_axi_ctl", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 0);
        chk("h_rst_busy_done", 32'({BUSY, DONE, TRACE_VALID}), 0);
        chk("h_rst_err", 32'(ERR), 0);
        chk("h_rst_result", RESULT, 0);
        chk("h_rst_trace_data", TRACE_DATA, 0);
        RESET = 1'b0;
        sl_reset = 1'b0;
        aw_delay = 0;
        result_val = 32'hCAFEF00D;
        tick();
        start_job(32'd4, 15'd1);
        wait_done("h");
        chk("h_err", 32'(ERR), 0);
        chk("h_result", RESULT, 32'hCAFEF00D);
        tick();
        chk("h_words", 32'(ntr), 1);
        chk("h_trace_word", trace_log[0], 32'd10);
        chk("h_b", 32'(nb), 2);
        chk("h_wdata", wr_data[0], 32'd4);
        chk("h_viol", 32'(viol), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
